// File: rtl/jt12_pkg.sv
// rtl/jt12_pkg.sv - shared constants and helpers for the jt12 delay line
//
// Purpose : default stage geometry and the slot counter width function
//           used by jt12_shreg and jt12_shreg_cnt.
// Contents: DEF_WIDTH, DEF_STAGES (6 channels x 4 operators), cw_of().
package jt12_pkg;

  localparam int DEF_WIDTH  = 5;
  localparam int DEF_STAGES = 24;

  // Slot counter width; a single stage still needs a 1-bit slot port.
  function automatic int cw_of(input int stages);
    return (stages > 1) ? $clog2(stages) : 1;
  endfunction

endpackage

// File: rtl/jt12_shreg_cnt.sv
// rtl/jt12_shreg_cnt.sv - wrapping slot counter with registered zero decode
//
// Purpose : tracks which slot is currently presented at the end of the
//           delay line; counts 0..STAGES-1 on cen-qualified edges.
// Ports   : clk  - clock
//           rst  - asynchronous active-high reset (slot=0, zero=1)
//           cen  - clock enable
//           slot - current slot index (CW bits)
//           zero - registered slot==0 flag
module jt12_shreg_cnt
  import jt12_pkg::*;
#(
  parameter  int STAGES = DEF_STAGES,
  localparam int CW     = cw_of(STAGES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  output logic [CW-1:0] slot,
  output logic          zero
);

  localparam logic [CW-1:0] LAST = CW'(STAGES - 1);

  logic [CW-1:0] slot_q, slot_d;
  logic          zero_q, zero_d;

  // Explicit wrap keeps non-power-of-two counts out of the unused codes.
  always_comb begin
    slot_d = slot_q;
    if (slot_q == LAST) begin
      slot_d = '0;
    end else begin
      slot_d = slot_q + CW'(1);
    end
    zero_d = (slot_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
      zero_q <= 1'b1;
    end else if (cen) begin
      slot_q <= slot_d;
      zero_q <= zero_d;
    end
  end

  assign slot = slot_q;
  assign zero = zero_q;

endmodule

// File: rtl/jt12_shreg.sv
// rtl/jt12_shreg.sv - clock-enabled multi-stage delay line with slot tracking
//
// Purpose : STAGES-deep, WIDTH-wide shift register advanced on cen; stage 1
//           loads din, or RSTVAL when clr is high.
// Ports   : clk, rst (async active-high), cen, clr, din[WIDTH]
//           drop[WIDTH]  - last stage contents (registered)
//           slot[CW]     - slot index currently at drop
//           zero         - registered slot==0 flag
//           tap_sel[CW], tap[WIDTH] - random-access tap, present only when
//           JT12_SHREG_TAP_EN is defined
// Config  : JT12_SHREG_TAP_EN enables the tap port.
module jt12_shreg
  import jt12_pkg::*;
#(
  parameter  int               WIDTH  = DEF_WIDTH,
  parameter  int               STAGES = DEF_STAGES,
  parameter  logic [WIDTH-1:0] RSTVAL = '0,
  localparam int               CW     = cw_of(STAGES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] drop,
  output logic [CW-1:0]    slot,
`ifdef JT12_SHREG_TAP_EN
  input  logic [CW-1:0]    tap_sel,
  output logic [WIDTH-1:0] tap,
`endif
  output logic             zero
);

  // stage_w[k] is the output of stage k+1.
  logic [WIDTH-1:0] stage_w [STAGES];

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] stage_q, stage_d;

      if (k == 0) begin : g_head
        assign stage_d = clr ? RSTVAL : din;
      end else begin : g_body
        assign stage_d = stage_w[k-1];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          stage_q <= RSTVAL;
        end else if (cen) begin
          stage_q <= stage_d;
        end
      end

      assign stage_w[k] = stage_q;
    end
  endgenerate

  assign drop = stage_w[STAGES-1];

  jt12_shreg_cnt #(
    .STAGES (STAGES)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .cen  (cen),
    .slot (slot),
    .zero (zero)
  );

`ifdef JT12_SHREG_TAP_EN
  logic [WIDTH-1:0] tap_q, tap_d;

  // The tap samples every clk so it can be read while the line is stalled.
  always_comb begin
    tap_d = RSTVAL;
    if (int'(tap_sel) < STAGES) begin
      tap_d = stage_w[tap_sel];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap_q <= RSTVAL;
    end else begin
      tap_q <= tap_d;
    end
  end

  assign tap = tap_q;
`endif

endmodule
